// File: rtl/beat_scheduler.sv
// Beat scheduler: qualifies baton direction changes into a beat stream with bar
// position, averaged period and timeout. Optional prediction via BEAT_PREDICT_EN.
module beat_scheduler #(
  parameter int unsigned PERIOD_W      = 27,
  parameter int unsigned MIN_GAP       = 10_000_000,
  parameter int unsigned MAX_GAP       = 100_000_000,
  parameter int unsigned AVG_SHIFT     = 2,
  parameter int unsigned BEATS_PER_BAR = 4
) (
  input  logic                clk_camera_in,
  input  logic                rst_n_in,
  input  logic                enable_in,
  input  logic                change_in,
  output logic                measure_out,
  output logic                beat_out,
  output logic                downbeat_out,
  output logic [2:0]          beat_index_out,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid_out,
  output logic                locked_out,
  output logic                timeout_out,
  output logic                predict_out
);

  localparam logic [PERIOD_W-1:0] MIN_G    = PERIOD_W'(MIN_GAP);
  localparam logic [PERIOD_W-1:0] MAX_G    = PERIOD_W'(MAX_GAP);
  localparam logic [2:0]          LAST_IDX = 3'(BEATS_PER_BAR - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRST,
    S_MEASURE,
    S_LOCKED
  } state_t;

  state_t                r_state;
  logic [PERIOD_W-1:0]   r_gap_cnt;
  logic [2:0]            r_index;

  logic                  w_tracking;
  logic                  w_in_window;
  logic                  w_timeout;
  logic                  w_accept;
  logic signed [PERIOD_W:0] w_diff;
  logic signed [PERIOD_W:0] w_step;
  logic [PERIOD_W-1:0]   w_avg;

  assign w_tracking  = (r_state == S_MEASURE) || (r_state == S_LOCKED);
  assign w_in_window = (r_gap_cnt >= MIN_G) && (r_gap_cnt < MAX_G);
  assign w_timeout   = w_tracking && (r_gap_cnt == MAX_G);
  assign w_accept    = change_in &&
                       ((r_state == S_FIRST) || (w_tracking && w_in_window && !w_timeout));

  // Signed difference one bit wider; the arithmetic shift floors toward -inf and
  // the sum always lands back inside PERIOD_W, so truncation is exact.
  assign w_diff = $signed({1'b0, r_gap_cnt}) - $signed({1'b0, period_out});
  assign w_step = w_diff >>> AVG_SHIFT;
  assign w_avg  = period_out + PERIOD_W'(w_step);

`ifdef BEAT_PREDICT_EN
  logic r_armed;
  logic w_predict;
  assign w_predict = (r_state == S_LOCKED) && r_armed && !w_accept &&
                     !w_timeout && (r_gap_cnt == period_out);
`endif

  always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state          <= S_IDLE;
      r_gap_cnt        <= '0;
      r_index          <= '0;
      measure_out      <= 1'b0;
      beat_out         <= 1'b0;
      downbeat_out     <= 1'b0;
      beat_index_out   <= '0;
      period_out       <= '0;
      period_valid_out <= 1'b0;
      locked_out       <= 1'b0;
      timeout_out      <= 1'b0;
`ifdef BEAT_PREDICT_EN
      r_armed          <= 1'b0;
      predict_out      <= 1'b0;
`endif
    end else begin
      beat_out     <= 1'b0;
      downbeat_out <= 1'b0;
      timeout_out  <= 1'b0;
`ifdef BEAT_PREDICT_EN
      predict_out  <= 1'b0;
`endif
      if (!enable_in) begin
        r_state          <= S_IDLE;
        r_gap_cnt        <= '0;
        r_index          <= '0;
        measure_out      <= 1'b0;
        period_valid_out <= 1'b0;
        locked_out       <= 1'b0;
`ifdef BEAT_PREDICT_EN
        r_armed          <= 1'b0;
`endif
      end else if (r_state == S_IDLE) begin
        r_state     <= S_FIRST;
        r_gap_cnt   <= '0;
        measure_out <= 1'b1;
      end else begin
        if (w_accept)
          r_gap_cnt <= PERIOD_W'(1);
        else if (r_gap_cnt != MAX_G)
          r_gap_cnt <= r_gap_cnt + PERIOD_W'(1);

        if (w_timeout) begin
          timeout_out      <= 1'b1;
          r_state          <= S_FIRST;
          r_index          <= '0;
          period_valid_out <= 1'b0;
          locked_out       <= 1'b0;
`ifdef BEAT_PREDICT_EN
          r_armed          <= 1'b0;
`endif
        end else if (w_accept) begin
          beat_out       <= 1'b1;
          downbeat_out   <= (r_index == 3'd0);
          beat_index_out <= r_index;
          r_index        <= (r_index == LAST_IDX) ? 3'd0 : r_index + 3'd1;
`ifdef BEAT_PREDICT_EN
          r_armed        <= 1'b1;
`endif
          case (r_state)
            S_FIRST: r_state <= S_MEASURE;
            S_MEASURE: begin
              r_state          <= S_LOCKED;
              locked_out       <= 1'b1;
              period_out       <= r_gap_cnt;
              period_valid_out <= 1'b1;
            end
            default: period_out <= w_avg;
          endcase
        end
`ifdef BEAT_PREDICT_EN
        else if (w_predict) begin
          predict_out <= 1'b1;
          r_armed     <= 1'b0;
        end
`endif
      end
    end
  end

`ifndef BEAT_PREDICT_EN
  assign predict_out = 1'b0;
`endif

endmodule

// File: tb/tb_beat_scheduler.sv
// Directed table-driven bench for beat_scheduler with a small test configuration.
module tb_beat_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       change;
  logic       measure, beat, downbeat, period_valid, locked, timeout, predict;
  logic [2:0] beat_index;
  logic [7:0] period;

  int checks = 0;
  int errors = 0;

  beat_scheduler #(
    .PERIOD_W(8),
    .MIN_GAP(4),
    .MAX_GAP(64),
    .AVG_SHIFT(2),
    .BEATS_PER_BAR(4)
  ) dut (
    .clk_camera_in   (clk),
    .rst_n_in        (rst_n),
    .enable_in       (enable),
    .change_in       (change),
    .measure_out     (measure),
    .beat_out        (beat),
    .downbeat_out    (downbeat),
    .beat_index_out  (beat_index),
    .period_out      (period),
    .period_valid_out(period_valid),
    .locked_out      (locked),
    .timeout_out     (timeout),
    .predict_out     (predict)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned wait_c;
    logic        chg;
    logic        beat;
    logic        down;
    logic [2:0]  idx;
    logic [7:0]  per;
    logic        valid;
    logic        locked;
    logic        tmo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait_c ticks after the previous change edge; the last one carries change_in.
  task automatic apply(input vec_t v, input int n);
    for (int k = 1; k < int'(v.wait_c); k++) begin
      tick();
      check($sformatf("v%0d idle beat", n), int'(beat), 0);
      check($sformatf("v%0d idle timeout", n), int'(timeout), 0);
    end
    change = v.chg;
    tick();
    change = 1'b0;
    check($sformatf("v%0d beat", n), int'(beat), int'(v.beat));
    check($sformatf("v%0d downbeat", n), int'(downbeat), int'(v.down));
    check($sformatf("v%0d index", n), int'(beat_index), int'(v.idx));
    check($sformatf("v%0d period", n), int'(period), int'(v.per));
    check($sformatf("v%0d valid", n), int'(period_valid), int'(v.valid));
    check($sformatf("v%0d locked", n), int'(locked), int'(v.locked));
    check($sformatf("v%0d timeout", n), int'(timeout), int'(v.tmo));
    check($sformatf("v%0d measure", n), int'(measure), 1);
    check($sformatf("v%0d predict", n), int'(predict), 0);
  endtask

  initial begin
    //           wait chg beat down idx per  val lck tmo
    vecs[0]  = '{10, 1'b1, 1'b1, 1'b1, 3'd0, 8'd0,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{20, 1'b1, 1'b1, 1'b0, 3'd1, 8'd20, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{24, 1'b1, 1'b1, 1'b0, 3'd2, 8'd21, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{12, 1'b1, 1'b1, 1'b0, 3'd3, 8'd18, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{2,  1'b1, 1'b0, 1'b0, 3'd3, 8'd18, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1,  1'b1, 1'b0, 1'b0, 3'd3, 8'd18, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1,  1'b1, 1'b1, 1'b1, 3'd0, 8'd14, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{20, 1'b1, 1'b1, 1'b0, 3'd1, 8'd15, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{63, 1'b1, 1'b1, 1'b0, 3'd2, 8'd27, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{64, 1'b1, 1'b0, 1'b0, 3'd2, 8'd27, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{5,  1'b1, 1'b1, 1'b1, 3'd0, 8'd27, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{10, 1'b1, 1'b1, 1'b0, 3'd1, 8'd10, 1'b1, 1'b1, 1'b0};

    rst_n  = 1'b0;
    enable = 1'b0;
    change = 1'b0;
    tick();
    tick();
    check("reset measure", int'(measure), 0);
    check("reset beat", int'(beat), 0);
    check("reset index", int'(beat_index), 0);
    check("reset period", int'(period), 0);
    check("reset valid", int'(period_valid), 0);
    check("reset locked", int'(locked), 0);
    check("reset timeout", int'(timeout), 0);

    rst_n = 1'b1;
    tick();
    check("idle measure", int'(measure), 0);
    change = 1'b1;
    tick();
    change = 1'b0;
    check("idle change ignored", int'(beat), 0);
    enable = 1'b1;
    tick();
    check("first measure", int'(measure), 1);

    for (int i = 0; i < 12; i++) apply(vecs[i], i);

    // Asynchronous reset mid-LOCKED, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("async measure", int'(measure), 0);
    check("async period", int'(period), 0);
    check("async valid", int'(period_valid), 0);
    check("async locked", int'(locked), 0);
    check("async index", int'(beat_index), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rerun measure", int'(measure), 1);
    apply(vecs[0], 20);
    apply(vecs[11], 21);

    enable = 1'b0;
    tick();
    check("disable measure", int'(measure), 0);
    check("disable locked", int'(locked), 0);
    check("disable valid", int'(period_valid), 0);
    check("disable period held", int'(period), 10);
    change = 1'b1;
    tick();
    change = 1'b0;
    check("disabled change ignored", int'(beat), 0);
    check("disabled measure", int'(measure), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beat_scheduler.md
Name: beat_scheduler

Overview:
- Sequences the baton tracker and turns its raw direction-change pulses into a qualified beat stream for the music back-end.
- Drives the tracker's measure enable, rejects spurious changes inside a refractory window, and measures inter-beat period with an exponential average.
- Tracks position within the bar and detects loss of conducting via timeout.
- Sits between the baton tracker and the note/tempo sequencer, all in the camera clock domain.

Parameters:
PERIOD_W, 27, width of the gap counter and the period.
MIN_GAP, 10_000_000, refractory cycles; changes arriving sooner than this after an accepted beat are dropped.
MAX_GAP, 100_000_000, gap counter saturation and timeout threshold; must be less than 2^PERIOD_W.
AVG_SHIFT, 2, averaging weight of 1/2^AVG_SHIFT applied to each new interval.
BEATS_PER_BAR, 4, beats per bar, 1..8.

Ports:
clk_camera_in  in  1  camera pixel clock; only clock.
rst_n_in  in  1  asynchronous, active-low reset.
enable_in  in  1  level; conducting session active.
change_in  in  1  one-cycle pulse from the baton tracker.
measure_out  out  1  drives tracker measure input.
beat_out  out  1  one-cycle qualified beat pulse.
downbeat_out  out  1  one-cycle pulse, coincident with beat_out when index is 0.
beat_index_out  out  3  position in bar of the current beat.
period_out  out  PERIOD_W  averaged beat period, in cycles.
period_valid_out  out  1  period_out holds a measured value.
locked_out  out  1  state is LOCKED.
timeout_out  out  1  one-cycle pulse on loss of beats.
predict_out  out  1  predicted beat pulse (optional feature).

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, gap_cnt 0, index 0, period_out 0.
- States:
  - IDLE: enable_in=1 -> FIRST.
  - FIRST: first change_in is accepted unconditionally -> MEASURE.
  - MEASURE: accepted change -> LOCKED.
  - LOCKED: accepted change stays in LOCKED.
  - From any state, enable_in=0 -> IDLE next cycle. On this transition, beat_out, downbeat_out, timeout_out, locked_out and period_valid_out clear; period_out holds.
- gap_cnt:
  - Set to 1 in the cycle after an accepted beat, then +1 per cycle, saturating at MAX_GAP.
  - The sample equals the cycle distance between accepted changes: changes at t and t+N give sample N.
- Acceptance (MEASURE/LOCKED): change_in with MIN_GAP <= gap_cnt < MAX_GAP. Otherwise the change is ignored with no state effect.
- Outputs on acceptance, all registered, latency 1:
  - beat_out=1.
  - downbeat_out=1 if the index before increment is 0.
  - beat_index_out = that pre-increment index.
  - The index then increments, wrapping BEATS_PER_BAR-1 -> 0.
  - The beat accepted in FIRST always has index 0.
- Period:
  - MEASURE acceptance: period_out <= sample, period_valid_out <= 1.
  - LOCKED acceptance: period_out <= period_out + ((sample - period_out) >>> AVG_SHIFT).
  - Difference computed signed at PERIOD_W+1 bits, arithmetic shift (rounds toward -inf); result fits PERIOD_W by construction.
- Timeout: in MEASURE/LOCKED, when gap_cnt reaches MAX_GAP:
  - timeout_out pulses once.
  - State -> FIRST; period_valid_out and locked_out clear; index -> 0; period_out holds.
  - A change_in in the same cycle as the timeout is dropped (timeout wins).
- measure_out: registered, 1 in FIRST/MEASURE/LOCKED, 0 in IDLE and reset.
- change_in in IDLE: ignored.

Optional Feature:
BEAT_PREDICT_EN:
- Defined: in LOCKED, predict_out pulses for one cycle when gap_cnt == period_out and no accepted change occurs that cycle, at most once per interval. Re-armed by the next accepted beat. Does not affect the index or the period.
- Undefined: predict_out tied to 0 and no prediction logic is built.

Test Plan:
All scenarios use PERIOD_W=8, MIN_GAP=4, MAX_GAP=64, AVG_SHIFT=2, BEATS_PER_BAR=4.
- Lock-in: enable, then changes at cycles 10, 30, 54 -> beat_out at 11/31/55; period_out=20 with valid and locked asserted after 30; period_out=21 after 54.
- Shrinking average: locked at period 20, next interval 12 -> period_out=18 (diff -8 >>>2 = -2).
- Refractory: change 2 cycles after an accepted beat -> no beat_out and no period change; change at gap 4 -> accepted.
- Bar count: 5 accepted beats -> beat_index_out 0,1,2,3,0; downbeat_out on beats 1 and 5.
- Timeout: locked, then 64 cycles without change -> one timeout_out pulse; locked/valid drop; period_out holds; next change is downbeat index 0. A change_in on the timeout cycle is ignored.
- Reset/enable: pull rst_n_in low mid-LOCKED -> all outputs 0 immediately without a clock edge. Drop enable_in -> IDLE; measure_out=0 next cycle.
